h264_mb_scheduler: RTL

H264_MB_SCHEDULER -- requirements
Module: h264_mb_scheduler

---
 rtl/h264_mb_scheduler_if.sv | 33 +++
 rtl/h264_mb_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/h264_mb_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// h264_mb_scheduler_if : frame-control, intra-buffer and header handshakes
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
interface h264_mb_scheduler_if #(
  parameter int DIMW = 8
);
  logic            START;
  logic [DIMW-1:0] WIDTH_MB;
  logic [DIMW-1:0] HEIGHT_MB;
  logic            NXINC;
  logic            DONE;
  logic            HDR_DONE;
  logic            NEWSLICE;
  logic            NEWLINE;
  logic            HDR_START;
  logic [DIMW-1:0] MBX;
  logic [DIMW-1:0] MBY;
  logic            BUSY;
  logic            FRAME_DONE;

  modport master (
    output START, WIDTH_MB, HEIGHT_MB, NXINC, DONE, HDR_DONE,
    input  NEWSLICE, NEWLINE, HDR_START, MBX, MBY, BUSY, FRAME_DONE
  );

  modport slave (
    input  START, WIDTH_MB, HEIGHT_MB, NXINC, DONE, HDR_DONE,
    output NEWSLICE, NEWLINE, HDR_START, MBX, MBY, BUSY, FRAME_DONE
  );
endinterface
`default_nettype wire

// File: rtl/h264_mb_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// h264_mb_scheduler : raster-order macroblock sequencer for one intra frame
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
module h264_mb_scheduler #(
  parameter int DIMW = 8
) (
  input wire                 CLK,
  input wire                 RST,
  h264_mb_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SLICE, HDR, MB, LINE, FLUSH, FIN} state_t;

  localparam logic [DIMW-1:0] c_one = DIMW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DIMW-1:0] r_w, r_h, r_mbx, r_mby;
  logic [DIMW-1:0] w_w_nxt, w_h_nxt, w_mbx_nxt, w_mby_nxt;
  logic            r_newslice, r_newline, r_hdr_start, r_frame_done, r_busy;
  logic            w_newslice_nxt, w_newline_nxt, w_hdr_start_nxt;
  logic            w_frame_done_nxt, w_busy_nxt;
  logic            r_rst_q;

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_h_nxt     = r_h;
    w_mbx_nxt   = r_mbx;
    w_mby_nxt   = r_mby;
    case (r_state)
      IDLE: begin
        if (bus.START && (bus.WIDTH_MB != '0) && (bus.HEIGHT_MB != '0)) begin
          w_w_nxt     = bus.WIDTH_MB;
          w_h_nxt     = bus.HEIGHT_MB;
          w_mbx_nxt   = '0;
          w_mby_nxt   = '0;
          w_state_nxt = SLICE;
        end
      end
      SLICE: w_state_nxt = HDR;
      HDR: begin
        if (bus.HDR_DONE) w_state_nxt = MB;
      end
      MB: begin
        if (bus.NXINC) begin
          if (r_mbx != r_w - c_one) begin
            w_mbx_nxt   = r_mbx + c_one;
            w_state_nxt = HDR;
          end else if (r_mby != r_h - c_one) begin
            w_mbx_nxt   = '0;
            w_mby_nxt   = r_mby + c_one;
            w_state_nxt = LINE;
          end else begin
            w_state_nxt = FLUSH;
          end
        end
      end
      LINE: w_state_nxt = HDR;
      FLUSH: begin
        if (bus.DONE) w_state_nxt = FIN;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Strobes are decoded from the state being entered so they leave a flop.
    // NEWSLICE is also held for the first cycle after reset release.
    w_newslice_nxt   = (w_state_nxt == SLICE) || r_rst_q;
    w_newline_nxt    = (w_state_nxt == LINE);
    w_hdr_start_nxt  = (w_state_nxt == HDR) && (r_state != HDR);
    w_frame_done_nxt = (w_state_nxt == FIN);
    w_busy_nxt       = (w_state_nxt != IDLE) && (w_state_nxt != FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_w          <= '0;
      r_h          <= '0;
      r_mbx        <= '0;
      r_mby        <= '0;
      r_newslice   <= 1'b1;
      r_newline    <= 1'b0;
      r_hdr_start  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_rst_q      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_w          <= w_w_nxt;
      r_h          <= w_h_nxt;
      r_mbx        <= w_mbx_nxt;
      r_mby        <= w_mby_nxt;
      r_newslice   <= w_newslice_nxt;
      r_newline    <= w_newline_nxt;
      r_hdr_start  <= w_hdr_start_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
      r_rst_q      <= 1'b0;
    end
  end

  assign bus.NEWSLICE   = r_newslice;
  assign bus.NEWLINE    = r_newline;
  assign bus.HDR_START  = r_hdr_start;
  assign bus.FRAME_DONE = r_frame_done;
  assign bus.BUSY       = r_busy;
  assign bus.MBX        = r_mbx;
  assign bus.MBY        = r_mby;
endmodule
`default_nettype wire
